// File: rtl/unsigned_seq_div_restoring_pkg.sv
// Shared definitions for the sequential restoring divider and its companion
// shift-add multiplier bench: default operand width and FSM state encoding.
// No ports; imported by the divider top and its iteration sub-module.
package unsigned_seq_div_restoring_pkg;

   // Default divisor/remainder width; dividend and quotient are twice this.
   localparam int N_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/unsigned_seq_div_restoring_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
// Ports: p (partial remainder, N+1), din (next dividend bit), b (divisor)
//        -> p_next (updated partial remainder), q (quotient bit).
module unsigned_seq_div_restoring_step
   import unsigned_seq_div_restoring_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N:0]   p,
   input  logic         din,
   input  logic [N-1:0] b,
   output logic [N:0]   p_next,
   output logic         q
);

   logic [N:0] p_shift;
   logic [N:0] b_ext;

   // The remainder is always < b before the shift, so dropping p[N] loses nothing.
   assign p_shift = {p[N-1:0], din};
   assign b_ext   = {1'b0, b};

   always_comb begin
      q      = 1'b0;
      p_next = p_shift;
      if (p_shift >= b_ext) begin
         q      = 1'b1;
         p_next = p_shift - b_ext;
      end
   end

endmodule

// File: rtl/unsigned_seq_div_restoring.sv
// Sequential unsigned restoring divider: 2N-bit a / N-bit b, one quotient bit
// per clock MSB first; done after 2N cycles, or one edge after load if b == 0.
// Ports: clk, rst (async, active-high), load, a, b -> quotient, remainder, busy, done, div_by_zero.
module unsigned_seq_div_restoring
   import unsigned_seq_div_restoring_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [2*N-1:0] a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero
);

   localparam int CW = $clog2(2*N);
   localparam logic [CW-1:0] LAST = CW'(2*N-1);

   state_t         state, state_nxt;
   logic [2*N-1:0] dvd,   dvd_nxt;     // dividend shift register
   logic [N-1:0]   dvs,   dvs_nxt;     // latched divisor
   logic [N:0]     prem,  prem_nxt;    // partial remainder
   logic [2*N-1:0] wq,    wq_nxt;      // working quotient
   logic [CW-1:0]  cnt,   cnt_nxt;
   logic [2*N-1:0] quotient_nxt;
   logic [N-1:0]   remainder_nxt;
   logic           busy_nxt, done_nxt, dbz_nxt;

   logic [N:0]     step_p;
   logic           step_q;

   unsigned_seq_div_restoring_step #(.N(N)) u_step (
      .p      (prem),
      .din    (dvd[2*N-1]),
      .b      (dvs),
      .p_next (step_p),
      .q      (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         dvd         <= '0;
         dvs         <= '0;
         prem        <= '0;
         wq          <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         dvd         <= dvd_nxt;
         dvs         <= dvs_nxt;
         prem        <= prem_nxt;
         wq          <= wq_nxt;
         cnt         <= cnt_nxt;
         quotient    <= quotient_nxt;
         remainder   <= remainder_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         div_by_zero <= dbz_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      dvd_nxt       = dvd;
      dvs_nxt       = dvs;
      prem_nxt      = prem;
      wq_nxt        = wq;
      cnt_nxt       = cnt;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      busy_nxt      = busy;
      done_nxt      = done;
      dbz_nxt       = div_by_zero;

      // load wins in every state, which also gives abort-and-restart during RUN.
      if (load) begin
         dvd_nxt  = a;
         dvs_nxt  = b;
         prem_nxt = '0;
         wq_nxt   = '0;
         cnt_nxt  = '0;
         if (b == '0) begin
            state_nxt     = DONE;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
            dbz_nxt       = 1'b1;
            quotient_nxt  = '1;
            remainder_nxt = '0;
         end else begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            dbz_nxt   = 1'b0;
         end
      end else begin
         unique case (state)
            IDLE: ;
            RUN: begin
               dvd_nxt  = {dvd[2*N-2:0], 1'b0};
               prem_nxt = step_p;
               wq_nxt   = {wq[2*N-2:0], step_q};
               if (cnt == LAST) begin
                  // Publish from the step outputs so the result lands on the last edge.
                  state_nxt     = DONE;
                  busy_nxt      = 1'b0;
                  done_nxt      = 1'b1;
                  quotient_nxt  = {wq[2*N-2:0], step_q};
                  remainder_nxt = step_p[N-1:0];
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            DONE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
module tb_unsigned_seq_div_restoring;

   localparam int N = 6;

   logic           clk;
   logic           rst;
   logic           load;
   logic [2*N-1:0] a;
   logic [N-1:0]   b;
   logic [2*N-1:0] quotient;
   logic [N-1:0]   remainder;
   logic           busy;
   logic           done;
   logic           div_by_zero;

   unsigned_seq_div_restoring #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .a           (a),
      .b           (b),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      int q;
      int r;
      int dbz;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Monitor: a completion is a sample with done high where done was low before,
   // or where a load was taken on the preceding edge (b==0 right after a result).
   initial begin : monitor
      logic ld;
      logic done_q;
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(posedge clk);
         ld = load & ~rst;
         @(negedge clk);
         if (done && (!done_q || ld)) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check({e.name, " quotient"},    int'(quotient),    e.q);
               check({e.name, " remainder"},   int'(remainder),   e.r);
               check({e.name, " div_by_zero"}, int'(div_by_zero), e.dbz);
            end
         end
         done_q = done;
      end
   end

   task automatic push(input string name, input int q, input int r, input int dbz);
      exp_t e;
      e.name = name; e.q = q; e.r = r; e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Pulse load for one edge; returns #1 after that edge.
   task automatic start(input int av, input int bv);
      a    = (2*N)'(av);
      b    = N'(bv);
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Counts edges after the load edge until done, and busy cycles in between.
   task automatic wait_done(input string name, input int exp_cycles);
      int cycles = 0;
      int busy_cycles = 0;
      while (!done && cycles < 40) begin
         if (busy) busy_cycles++;
         @(posedge clk);
         #1;
         cycles++;
      end
      check({name, " latency"},     cycles,      exp_cycles);
      check({name, " busy_cycles"}, busy_cycles, exp_cycles);
      check({name, " done"},        int'(done),  1);
   endtask

   task automatic run_op(input string name, input int av, input int bv,
                         input int q, input int r);
      push(name, q, r, 0);
      start(av, bv);
      wait_done(name, 2*N);
   endtask

   initial begin : stimulus
      int bad;
      rst  = 1'b1;
      load = 1'b0;
      a    = '0;
      b    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset quotient",    int'(quotient),    0);
      check("reset remainder",   int'(remainder),   0);
      check("reset busy",        int'(busy),        0);
      check("reset done",        int'(done),        0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("100/7",  100,  7, 14,   2);
      run_op("4095/63", 4095, 63, 65,  0);
      run_op("4095/1",  4095, 1, 4095, 0);
      run_op("5/9",     5,    9, 0,    5);

      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (quotient != 0 || remainder != 5 || !done || busy) bad++;
      end
      check("hold_after_done bad_cycles", bad, 0);

      // Divide by zero straight after a completed result: done stays high.
      push("1234/0", 4095, 0, 1);
      start(1234, 0);
      check("1234/0 busy",     int'(busy), 0);
      wait_done("1234/0", 0);

      // Abort: restart mid-run; only the second operation may report.
      start(100, 7);
      repeat (4) @(posedge clk);
      #1;
      check("abort busy_before_reload", int'(busy), 1);
      run_op("50/6 after abort", 50, 6, 8, 2);

      // Asynchronous reset in the middle of a clock phase during RUN.
      start(100, 7);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst quotient",    int'(quotient),    0);
      check("async_rst remainder",   int'(remainder),   0);
      check("async_rst busy",        int'(busy),        0);
      check("async_rst done",        int'(done),        0);
      check("async_rst div_by_zero", int'(div_by_zero), 0);
      #10;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("63/8 after rst", 63, 8, 7, 7);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_leftover", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog timeout");
   end

endmodule

// File: doc/unsigned_seq_div_restoring.md
Name: unsigned_seq_div_restoring

Overview:
Sequential unsigned restoring divider. It is the inverse datapath to the team's shift-add sequential multiplier. It divides a 2N-bit dividend by an N-bit divisor, producing one quotient bit per clock, MSB first. It is used to check multiplier results (a*b / b == a) and as a standalone divide unit in the COA lab datapath.

Parameters:
N, 6, divisor/remainder width; the dividend and quotient are 2N bits wide.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  synchronous start: sample dividend/divisor and begin a division
a  input  2N  dividend, unsigned
b  input  N  divisor, unsigned
quotient  output reg  2N  result quotient, updated only at completion
remainder  output reg  N  result remainder, updated only at completion
busy  output reg  1  high while an iteration sequence is running
done  output reg  1  high from completion until the next load or rst
div_by_zero  output reg  1  high with done when the sampled b was 0

Behaviour:
- Reset is asynchronous and active-high. While rst is high: state IDLE; quotient, remainder, busy, done, div_by_zero are all 0; internal registers and the counter are cleared. Reset mid-division discards the operation with no partial result.
- States:
  - IDLE: wait for load.
  - RUN: one iteration per cycle.
  - DONE: hold the result.
- load is sampled at every rising edge in every state and has priority over everything except rst.
  - On load with b != 0: latch a into the dividend shift register and b into the divisor register. Clear the partial remainder (N+1 bits), working quotient and counter. Next state RUN, busy=1, done=0, div_by_zero=0. quotient/remainder outputs keep their previous values.
  - On load with b == 0: next state DONE, done=1, div_by_zero=1, busy=0, quotient = all ones (2N bits), remainder = 0. No iterations run.
- Each RUN iteration, at cnt = 0..2N-1:
  - P' = {P[N-1:0], D[2N-1]}, then shift D left by 1.
  - If P' >= {0,B}: P = P' - B and the quotient bit shifted in is 1; otherwise P = P' and the bit is 0.
  - The working quotient shifts left, bit entering at LSB.
  - cnt increments.
- Completion, on the edge that executes cnt = 2N-1:
  - state becomes DONE; busy=0, done=1.
  - quotient = final working quotient; remainder = final P[N-1:0].
- Latency: with load sampled at edge k, done and valid outputs appear after edge k+2N (12 cycles for N=6). busy is high for exactly 2N cycles.
- DONE holds the outputs and done=1 indefinitely. A new load restarts the sequence and clears done on that edge.
- load during RUN aborts the current division and restarts with the new operands. No done pulse is produced for the aborted operation.
- load held high for several cycles keeps re-sampling, so the division starts on the last edge at which load is high.
- Invariant at done with div_by_zero=0: quotient*b + remainder == a and remainder < b.
- The counter is sized to hold 2N-1 (4 bits for N=6). It never wraps, because leaving RUN stops counting.

Decomposition:
- Shared package holds the state encoding localparams (IDLE, RUN, DONE) and the default width N=6, shared with the multiplier bench.
- One natural sub-module, div_step: combinational single restoring iteration. Inputs are the partial remainder (N+1), the incoming dividend bit and the divisor (N). Outputs are the next partial remainder and the quotient bit.
- The FSM, counter and registers stay in the top module.

Test Plan:
- a=100, b=7, load one cycle -> busy high 12 cycles, then done=1, quotient=14, remainder=2, div_by_zero=0.
- a=4095, b=63 -> quotient=65, remainder=0. Then a=4095, b=1 -> quotient=4095, remainder=0.
- a=5, b=9 (dividend < divisor) -> quotient=0, remainder=5 after 12 cycles; outputs hold steady for 20 further cycles while done stays 1.
- a=1234, b=0 -> one edge after load: done=1, div_by_zero=1, quotient=4095, remainder=0, busy never asserted.
- Start a=100, b=7, assert load with a=50, b=6 at iteration 5 -> no done for the first operation. Exactly 12 cycles after the second load: quotient=8, remainder=2.
- Assert rst asynchronously (mid-cycle) during RUN -> all outputs read 0 immediately. After rst deasserts, a fresh load with a=63, b=8 gives quotient=7, remainder=7.
